// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns PC/nPC, reads instruction words over the
// RAM_enable/MFC handshake and hands them to decode with SPARC delayed-CTI sequencing.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MFC_TIMEOUT = 15,
    parameter logic [5:0]  RD_WORD_OP  = 6'b000000
) (
    input  logic        Clk,
    input  logic        RESET,
    input  logic        fetch_en,
    output logic        RAM_enable,
    output logic [5:0]  RAM_OpCode,
    output logic [31:0] mem_addr,
    input  logic        MFC,
    input  logic [31:0] mem_data,
    output logic [31:0] IR_Out,
    output logic        ir_valid,
    input  logic        ir_ack,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    output logic [31:0] PC_out,
    output logic [31:0] nPC_out,
    output logic        call_link,
    output logic [31:0] link_addr,
    output logic        fetch_fault,
    input  logic        fault_clr
);

    localparam int unsigned AW  = 32;
    localparam int unsigned OPW = 6;
    localparam int unsigned TW  = 4;
    localparam logic [TW-1:0] TIMER_LAST = TW'(MFC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [AW-1:0]  npc_q, npc_d;
    logic [AW-1:0]  ir_q, ir_d;
    logic           ir_valid_q, ir_valid_d;
    logic           ram_en_q, ram_en_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic           call_link_q, call_link_d;
    logic [AW-1:0]  link_addr_q, link_addr_d;
    logic           fault_q, fault_d;
    logic [TW-1:0]  timer_q, timer_d;

    // Reset also drops RAM_enable immediately, abandoning any in-flight read.
    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            npc_q       <= RESET_PC + AW'(4);
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            opcode_q    <= '0;
            mem_addr_q  <= RESET_PC;
            call_link_q <= 1'b0;
            link_addr_q <= '0;
            fault_q     <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            ram_en_q    <= ram_en_d;
            opcode_q    <= opcode_d;
            mem_addr_q  <= mem_addr_d;
            call_link_q <= call_link_d;
            link_addr_q <= link_addr_d;
            fault_q     <= fault_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        ram_en_d    = ram_en_q;
        link_addr_d = link_addr_q;
        call_link_d = 1'b0;
        fault_d     = fault_q;
        timer_d     = timer_q;

        case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (pc_q[1:0] != 2'b00) begin
                    fault_d = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    ram_en_d = 1'b1;
                    timer_d  = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // MFC wins over a timer expiring in the same cycle.
                if (MFC) begin
                    ir_d       = mem_data;
                    ir_valid_d = 1'b1;
                    ram_en_d   = 1'b0;
                    state_d    = S_HOLD;
                end else if (timer_q == TIMER_LAST) begin
                    fault_d  = 1'b1;
                    ram_en_d = 1'b0;
                    state_d  = S_FAULT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_HOLD: begin
                if (ir_ack && ir_valid_q) begin
                    pc_d = npc_q;
                    if (redirect) begin
                        npc_d = redirect_addr;
                    end else if (ir_q[31:30] == 2'b01) begin
                        npc_d       = pc_q + {ir_q[29:0], 2'b00};
                        call_link_d = 1'b1;
                        link_addr_d = pc_q;
                    end else begin
                        npc_d = npc_q + AW'(4);
                    end
                    ir_valid_d = 1'b0;
                    state_d    = fetch_en ? S_REQ : S_IDLE;
                end
            end
            S_FAULT: begin
                ir_valid_d = 1'b0;
                ram_en_d   = 1'b0;
                if (fault_clr) begin
                    fault_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        opcode_d   = ram_en_d ? RD_WORD_OP : '0;
        mem_addr_d = pc_d;
    end

    assign RAM_enable  = ram_en_q;
    assign RAM_OpCode  = opcode_q;
    assign mem_addr    = mem_addr_q;
    assign IR_Out      = ir_q;
    assign ir_valid    = ir_valid_q;
    assign PC_out      = pc_q;
    assign nPC_out     = npc_q;
    assign call_link   = call_link_q;
    assign link_addr   = link_addr_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of fetch/ack transactions
// followed by hand-written fault, timeout and reset sequences.
module tb_instr_fetch_unit;

    logic        Clk = 1'b0;
    logic        RESET;
    logic        fetch_en;
    logic        RAM_enable;
    logic [5:0]  RAM_OpCode;
    logic [31:0] mem_addr;
    logic        MFC;
    logic [31:0] mem_data;
    logic [31:0] IR_Out;
    logic        ir_valid;
    logic        ir_ack;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] PC_out;
    logic [31:0] nPC_out;
    logic        call_link;
    logic [31:0] link_addr;
    logic        fetch_fault;
    logic        fault_clr;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit dut (
        .Clk           (Clk),
        .RESET         (RESET),
        .fetch_en      (fetch_en),
        .RAM_enable    (RAM_enable),
        .RAM_OpCode    (RAM_OpCode),
        .mem_addr      (mem_addr),
        .MFC           (MFC),
        .mem_data      (mem_data),
        .IR_Out        (IR_Out),
        .ir_valid      (ir_valid),
        .ir_ack        (ir_ack),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .PC_out        (PC_out),
        .nPC_out       (nPC_out),
        .call_link     (call_link),
        .link_addr     (link_addr),
        .fetch_fault   (fetch_fault),
        .fault_clr     (fault_clr)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] data;
        int unsigned dly;
        logic        redir;
        logic [31:0] raddr;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_npc;
        logic        exp_call;
        logic [31:0] exp_link;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 8; i++) begin
            if (RAM_enable) break;
            step();
        end
        chk("req_seen", 32'(RAM_enable), 32'd1);
    endtask

    initial begin
        bit saw_en;

        //            data          dly redir raddr          addr           pc             npc            call link
        vecs[0] = '{32'h8200_2003, 2,  1'b0, 32'h0,         32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 1'b0, 32'h0};
        vecs[1] = '{32'h4000_0008, 1,  1'b0, 32'h0,         32'h0000_0004, 32'h0000_0008, 32'h0000_0024, 1'b1, 32'h4};
        vecs[2] = '{32'h4000_0010, 1,  1'b1, 32'h0000_0100, 32'h0000_0008, 32'h0000_0024, 32'h0000_0100, 1'b0, 32'h0};
        vecs[3] = '{32'h0100_0000, 3,  1'b0, 32'h0,         32'h0000_0024, 32'h0000_0100, 32'h0000_0104, 1'b0, 32'h0};
        vecs[4] = '{32'h7FFF_FFFF, 1,  1'b0, 32'h0,         32'h0000_0100, 32'h0000_0104, 32'h0000_00FC, 1'b1, 32'h100};
        vecs[5] = '{32'h0000_0000, 1,  1'b1, 32'hFFFF_FFFC, 32'h0000_0104, 32'h0000_00FC, 32'hFFFF_FFFC, 1'b0, 32'h0};
        vecs[6] = '{32'h0000_0000, 1,  1'b0, 32'h0,         32'h0000_00FC, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0};
        vecs[7] = '{32'h0000_0000, 15, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 1'b0, 32'h0};
        vecs[8] = '{32'h4000_0001, 1,  1'b1, 32'h0000_0102, 32'h0000_0000, 32'h0000_0004, 32'h0000_0102, 1'b0, 32'h0};
        vecs[9] = '{32'h0000_0000, 1,  1'b0, 32'h0,         32'h0000_0004, 32'h0000_0102, 32'h0000_0106, 1'b0, 32'h0};

        RESET = 1'b0; fetch_en = 1'b0; MFC = 1'b0; mem_data = '0;
        ir_ack = 1'b0; redirect = 1'b0; redirect_addr = '0; fault_clr = 1'b0;
        step();
        step();
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_npc", nPC_out, 32'h4);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_ctl", {26'd0, RAM_enable, ir_valid, call_link, fetch_fault, 2'b00}, 32'h0);
        chk("rst_ir", IR_Out, 32'h0);
        RESET = 1'b1;
        fetch_en = 1'b1;

        for (int v = 0; v < 10; v++) begin
            wait_req();
            chk($sformatf("v%0d_addr", v), mem_addr, vecs[v].exp_addr);
            chk($sformatf("v%0d_op", v), 32'(RAM_OpCode), 32'h0);
            for (int k = 1; k < int'(vecs[v].dly); k++) begin
                step();
                chk($sformatf("v%0d_wait_en", v), {31'd0, RAM_enable}, 32'd1);
            end
            MFC = 1'b1;
            mem_data = vecs[v].data;
            step();
            MFC = 1'b0;
            mem_data = 32'hDEAD_BEEF;
            chk($sformatf("v%0d_ir", v), IR_Out, vecs[v].data);
            chk($sformatf("v%0d_valid", v), {31'd0, ir_valid}, 32'd1);
            chk($sformatf("v%0d_en_drop", v), {31'd0, RAM_enable}, 32'd0);
            ir_ack = 1'b1;
            redirect = vecs[v].redir;
            redirect_addr = vecs[v].raddr;
            step();
            ir_ack = 1'b0;
            redirect = 1'b0;
            chk($sformatf("v%0d_pc", v), PC_out, vecs[v].exp_pc);
            chk($sformatf("v%0d_npc", v), nPC_out, vecs[v].exp_npc);
            chk($sformatf("v%0d_call", v), {31'd0, call_link}, {31'd0, vecs[v].exp_call});
            chk($sformatf("v%0d_vclr", v), {31'd0, ir_valid}, 32'd0);
            if (vecs[v].exp_call) chk($sformatf("v%0d_link", v), link_addr, vecs[v].exp_link);
        end

        // Misaligned PC 0x102 reaches REQ: fault without any memory request.
        saw_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (RAM_enable) saw_en = 1'b1;
        end
        chk("mis_no_req", {31'd0, saw_en}, 32'd0);
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_valid", {31'd0, ir_valid}, 32'd0);
        fetch_en = 1'b0;
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("mis_clr", {31'd0, fetch_fault}, 32'd0);
        chk("mis_pc", PC_out, 32'h102);
        chk("mis_npc", nPC_out, 32'h106);

        // Timeout: MFC withheld, fault lands after the 15th WAIT cycle.
        RESET = 1'b0;
        step();
        RESET = 1'b1;
        fetch_en = 1'b1;
        wait_req();
        fetch_en = 1'b0;
        repeat (14) step();
        chk("to_not_yet", {30'd0, RAM_enable, fetch_fault}, 32'h2);
        step();
        chk("to_fault", {31'd0, fetch_fault}, 32'd1);
        chk("to_en", {31'd0, RAM_enable}, 32'd0);
        chk("to_valid", {31'd0, ir_valid}, 32'd0);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("to_clr", {31'd0, fetch_fault}, 32'd0);
        chk("to_pc", PC_out, 32'h0);

        // Reset in the middle of WAIT, then a stray MFC.
        fetch_en = 1'b1;
        wait_req();
        step();
        RESET = 1'b0;
        #1;
        chk("rw_en_async", {31'd0, RAM_enable}, 32'd0);
        chk("rw_pc", PC_out, 32'h0);
        step();
        RESET = 1'b1;
        fetch_en = 1'b0;
        MFC = 1'b1;
        mem_data = 32'h1234_5678;
        step();
        MFC = 1'b0;
        step();
        chk("rw_valid", {31'd0, ir_valid}, 32'd0);
        chk("rw_ir", IR_Out, 32'h0);
        chk("rw_en", {31'd0, RAM_enable}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting directly upstream of the IR/ControlUnit decode path.
- Owns PC/nPC and issues word reads to RAM using the RAM_enable/RAM_OpCode/MFC handshake.
- Latches the returned word as IR and presents it to the ControlUnit with a valid/ack handshake.
- Applies SPARC delayed-control-transfer sequencing: normal increment, CALL target (disp30), external redirect for branches/jumps; asserts call_link for the r15 writeback.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; nPC resets to RESET_PC+4.
MFC_TIMEOUT, 15, max WAIT cycles without MFC before fetch fault (4-bit counter).
RD_WORD_OP, 6'b000000, RAM_OpCode driven for a word read.

Ports:
Clk  in  1  clock, all state on rising edge.
RESET  in  1  asynchronous, active-low reset.
fetch_en  in  1  allow new fetches.
RAM_enable  out  1  memory request, held high through WAIT.
RAM_OpCode  out  6  RD_WORD_OP while RAM_enable, else 0.
mem_addr  out  32  fetch address (= PC).
MFC  in  1  memory function complete, single-cycle pulse.
mem_data  in  32  read data, valid in the MFC cycle.
IR_Out  out  32  fetched instruction.
ir_valid  out  1  IR_Out holds an unconsumed instruction.
ir_ack  in  1  ControlUnit consumed IR_Out.
redirect  in  1  taken CTI; sampled only with ir_ack.
redirect_addr  in  32  CTI target.
PC_out  out  32  current PC.
nPC_out  out  32  current nPC.
call_link  out  1  one-cycle pulse when a CALL retires.
link_addr  out  32  address of the retiring CALL, valid with call_link.
fetch_fault  out  1  sticky fault (timeout or misaligned PC).
fault_clr  in  1  clears fault, returns to IDLE.

Behaviour:
- Reset (RESET=0, async):
  - PC=RESET_PC, nPC=RESET_PC+4, state IDLE.
  - IR_Out=0, ir_valid=0, RAM_enable=0, RAM_OpCode=0, mem_addr=RESET_PC.
  - call_link=0, link_addr=0, fetch_fault=0, timer=0.
  - A reset asserted mid-WAIT drops RAM_enable immediately; any late MFC is ignored.
- States: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE:
  - fetch_en=1 -> REQ next cycle.
  - Otherwise stay; all outputs quiet.
- REQ (1 cycle):
  - If PC[1:0]!=0: fetch_fault=1, go to FAULT, and no RAM_enable is issued.
  - Else: RAM_enable=1, RAM_OpCode=RD_WORD_OP, mem_addr=PC, timer=0, go to WAIT.
- WAIT:
  - RAM_enable, RAM_OpCode and mem_addr are held.
  - MFC=1: IR_Out<=mem_data, ir_valid<=1, RAM_enable<=0, go to HOLD.
  - Otherwise timer++.
  - When timer==MFC_TIMEOUT without MFC: fetch_fault<=1, RAM_enable<=0, go to FAULT.
  - MFC arriving in the same cycle the timer expires counts as success.
- HOLD:
  - IR_Out is stable and ir_valid=1 until ir_ack.
  - ir_ack is ignored when ir_valid=0.
  - On ir_ack, with A = current PC, the next values are:
    - redirect=1: PC<=nPC, nPC<=redirect_addr. Redirect has priority over CALL.
    - else IR_Out[31:30]==2'b01 (CALL): PC<=nPC, nPC<=A+{IR_Out[29:0],2'b00}; call_link=1 for one cycle, link_addr=A.
    - else: PC<=nPC, nPC<=nPC+4.
  - In all three cases ir_valid<=0.
  - Next state is REQ if fetch_en=1 (zero-bubble back-to-back), else IDLE.
- FAULT:
  - No requests; ir_valid=0.
  - fault_clr=1 -> fetch_fault<=0, go to IDLE. PC/nPC are unchanged.
- Arithmetic:
  - All address math is 32-bit, modulo 2^32. nPC=32'hFFFF_FFFC +4 wraps to 0.
  - CALL displacement is effectively sign-correct via wrap.
- fetch_en deasserted during WAIT/HOLD does not abort the in-flight fetch; it only blocks the next REQ.
- Latency:
  - REQ->WAIT->HOLD; IR valid one cycle after MFC.
  - Minimum 3 cycles per instruction with MFC in the first WAIT cycle and immediate ack.

Test Plan:
1. Reset, fetch_en=1, RAM returns 32'h8200_2003 with MFC on the 2nd WAIT cycle.
   - mem_addr=0, RAM_OpCode=RD_WORD_OP.
   - IR_Out=32'h8200_2003, ir_valid=1.
   - After ack: PC=4, nPC=8.
2. PC=4, nPC=8, fetch returns CALL 32'h4000_0008, then ack.
   - call_link pulse with link_addr=4.
   - PC=8, nPC=4+32=36.
   - Next mem_addr=8 (delay slot).
3. ir_ack with redirect=1, redirect_addr=32'h100 while IR holds a CALL.
   - nPC=32'h100, call_link stays 0.
4. Withhold MFC for 15 cycles.
   - fetch_fault=1, RAM_enable=0, ir_valid=0.
   - fault_clr -> IDLE with PC unchanged.
5. redirect_addr=32'h102 retired, then two acks.
   - On reaching REQ with PC=32'h102: fetch_fault=1, RAM_enable never asserts.
6. RESET low during WAIT, then MFC pulse.
   - RAM_enable drops asynchronously.
   - PC=RESET_PC, ir_valid stays 0, MFC ignored.
